// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
// ------------
// Multi-cycle multiply/divide sequencer with the architectural HI/LO
// registers. It lives in the E stage next to the ALU. A mult/multu/div/divu
// is captured on the edge it is seen in IDLE. The result is computed
// immediately into pending registers. The unit then stays busy for a fixed
// number of cycles and commits the pending result to HI/LO. mthi/mtlo write
// HI/LO directly in a single cycle.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   E_md_op   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mthi, 6 mtlo, 7 reserved (no-op)
//   E_rs_val  forwarded rs operand
//   E_rt_val  forwarded rt operand
//   E_rd_sel  read select for rd_data: 0 LO, 1 HI
//   D_md_use  D-stage instruction touches the multiply/divide unit
//   md_cancel abort the in-flight operation (only with MD_CANCEL_EN)
//   busy      operation in flight
//   md_stall  stall request to the hazard unit
//   hi, lo    architectural HI/LO
//   rd_data   committed HI or LO selected by E_rd_sel
//
// Build option:
//   MD_CANCEL_EN  when defined, md_cancel aborts an in-flight operation and
//                 suppresses a start. When undefined, md_cancel is ignored.

module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_rd_sel,
  input  logic        D_md_use,
  input  logic        md_cancel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

`ifdef MD_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          start;
  logic          cancel;
  logic          is_div;
  logic          is_signed;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_wr;
  logic [CW-1:0] res_cycles;

  logic [63:0]   prod;
  logic          rs_neg;
  logic          rt_neg;
  logic [31:0]   rs_mag;
  logic [31:0]   rt_mag;
  logic [31:0]   divisor;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;

  // md_cancel is folded to zero when the cancel option is not built in.
  assign cancel = md_cancel & CANCEL_EN;

  // The stall uses the raw start decode, so the hazard logic sees the request
  // in the same cycle the op arrives in E.
  assign start    = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                    (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
  assign md_stall = D_md_use & (start | busy);
  assign rd_data  = E_rd_sel ? hi : lo;

  // The result datapath is evaluated in the start cycle.
  // The division works on magnitudes and then restores the signs. This makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 and avoids relying
  // on the simulator's signed-overflow behaviour. A zero divisor is replaced
  // by 1 so the divider never produces X. The result is then marked as
  // not-to-be-written, which leaves HI/LO untouched at commit.
  always_comb begin
    is_div     = (E_md_op == OP_DIV) || (E_md_op == OP_DIVU);
    is_signed  = (E_md_op == OP_MULT) || (E_md_op == OP_DIV);
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_wr     = 1'b1;
    res_cycles = CW'(MULT_CYCLES);

    if (is_signed)
      prod = $signed({{32{E_rs_val[31]}}, E_rs_val}) * $signed({{32{E_rt_val[31]}}, E_rt_val});
    else
      prod = {32'd0, E_rs_val} * {32'd0, E_rt_val};

    rs_neg  = is_signed & E_rs_val[31];
    rt_neg  = is_signed & E_rt_val[31];
    rs_mag  = rs_neg ? (32'd0 - E_rs_val) : E_rs_val;
    rt_mag  = rt_neg ? (32'd0 - E_rt_val) : E_rt_val;
    divisor = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    q_mag   = rs_mag / divisor;
    r_mag   = rs_mag % divisor;

    if (is_div) begin
      res_cycles = CW'(DIV_CYCLES);
      res_wr     = (E_rt_val != 32'd0);
      res_lo     = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi     = rs_neg ? (32'd0 - r_mag) : r_mag;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Sequencer: IDLE accepts a start or an mthi/mtlo. RUN counts down
  // and commits the pending result on the last busy edge. A cancel in RUN
  // wins over that commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            count   <= res_cycles;
            busy    <= 1'b1;
            state   <= RUN;
          end else if (E_md_op == OP_MTHI) begin
            hi <= E_rs_val;
          end else if (E_md_op == OP_MTLO) begin
            lo <= E_rs_val;
          end
        end
        RUN: begin
          if (cancel) begin
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (count == CW'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            pend_wr <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The hazard unit must never issue a new multiply/divide op while one is in
  // flight. An op arriving in RUN would be silently dropped.
  assert property (@(posedge clk) disable iff (reset)
                   (state == RUN) |-> (E_md_op == 3'd0 || E_md_op == 3'd7));

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with HI/LO registers for the five-stage pipeline; sits in E stage beside the ALU.
- Accepts one mult/multu/div/divu per start, counts out the fixed latency, then commits HI/LO.
- Generates the D-stage stall request for HI/LO-touching instructions and serves mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- E_md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- E_rs_val  in  32  forwarded rs operand
- E_rt_val  in  32  forwarded rt operand
- E_rd_sel  in  1  read select: 0 LO, 1 HI
- D_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_cancel  in  1  abort in-flight op (MD_CANCEL_EN only)
- busy  out  1  operation in flight
- md_stall  out  1  stall request to hazard logic
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- rd_data  out  32  E_rd_sel ? hi : lo (combinational)

Behaviour:
- Reset (async, immediate): busy=0, counter=0, hi=0, lo=0, pending result regs=0, md_stall follows combinational equation.
- States: IDLE, RUN. In IDLE busy=0; in RUN busy=1.
- start = E_md_op in {1,2,3,4}.
- IDLE + start at edge T: compute result from E_rs_val/E_rt_val into pending regs; load counter with N (MULT_CYCLES or DIV_CYCLES); go RUN. busy high cycles T+1..T+N.
- RUN: counter decrements each edge; on the edge where counter==1, commit pending to hi/lo, go IDLE. New hi/lo and busy=0 visible in cycle T+N+1.
- start or mthi/mtlo seen while in RUN: ignored (hazard logic guarantees absence; verify via assertion).
- mthi (5) in IDLE: hi<=E_rs_val next edge, lo unchanged. mtlo (6): lo<=E_rs_val, hi unchanged. Single-cycle, no busy.
- mult: signed 32x32 -> 64, {hi,lo}. multu: unsigned.
- div: lo=quotient truncated toward zero, hi=remainder with dividend's sign. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu): full DIV_CYCLES busy sequence runs, hi/lo unchanged at commit.
- md_stall = D_md_use & (start | busy). Combinational, no registered delay.
- rd_data reflects committed hi/lo only; never pending values.
- Reset asserted in RUN: operation discarded, hi/lo=0.

Optional Feature:
- Macro MD_CANCEL_EN.
- Defined: md_cancel=1 at an edge in RUN -> go IDLE, busy=0 next cycle, pending discarded, hi/lo unchanged. md_cancel in IDLE with start -> start suppressed. md_cancel takes priority over commit on the same edge.
- Undefined: md_cancel port present but ignored. Every started op always commits.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu 0xFFFFFFFF x 2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; rd_data=lo with E_rd_sel=0.
- div -7/2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 5/0 -> after 10 cycles hi/lo unchanged.
- div started with D_md_use=1 -> md_stall=1 in start cycle and all 10 busy cycles, 0 on cycle 11. D_md_use=0 -> md_stall=0 throughout.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 -> hi/lo updated on successive edges, busy stays 0. Reset pulse mid-div (cycle 4) -> busy=0, hi=lo=0 immediately.
- MD_CANCEL_EN: mult, cancel at busy cycle 3 -> busy=0 next cycle, hi/lo retain prior values.
